multi_prescaler: RTL and testbench
==================================

Name: multi_prescaler

Overview:
- Multi-channel, parametrised clock-enable generator. Divides clk into NUM_CH independent single-cycle enable pulses, each with its own run-time divide value.
- Adds several behaviours: glitch-free divide reload, one-shot mode, a global phase-sync input, and a configurable-depth delayed pulse per channel for DPRAM read/write separation.
- Sits between the 50 MHz system clock and the audio DAC, tone and sequencer modules, so the whole design stays globally synchronous.

Parameters:
- NUM_CH, 4: number of independent channels.
- CNT_W, 16: width of each divide value and counter.
- DLY, 1: delay in clk cycles of pulse_d relative to pulse. Legal range 1..8.

Ports:
- clk  in  1  system clock, 50 MHz.
- resetN  in  1  asynchronous, active-low reset.
- ch_en  in  NUM_CH  per-channel run enable (level).
- oneshot  in  NUM_CH  per-channel mode: 0 = continuous, 1 = one-shot (level).
- start  in  NUM_CH  per-channel one-shot trigger (1-cycle pulse).
- sync  in  1  global phase realign (1-cycle pulse).
- div_wr  in  NUM_CH  per-channel write strobe for div_val.
- div_val  in  CNT_W  divide value written to every channel whose div_wr bit is set.
- pulse  out  NUM_CH  enable pulse, 1 clk wide.
- pulse_d  out  NUM_CH  pulse delayed by DLY clks.
- active  out  NUM_CH  channel is counting.

Behaviour:
- Reset (async, resetN=0):
  - All counters, pulse, pulse_d, active and delay lines are cleared to 0.
  - Both the shadow and the working divide registers are set to 0.
- Per channel there are two divide registers: a shadow register (written by div_wr) and a working register (used for the compare).
- Working register load rules:
  - Loaded from the shadow register when the counter wraps.
  - Also loaded from the shadow register on any cycle the channel is not active, so a reload is never applied mid-period.
- Counting, when the channel is active:
  - If cnt >= working divide: cnt <= 0 and pulse <= 1 on the next edge.
  - Otherwise: cnt <= cnt+1 and pulse <= 0.
  - Period is therefore divide+1 clks. Divide 0 gives pulse=1 on every active cycle.
  - pulse is registered: it rises on the edge where cnt returns to 0.
- Continuous mode (oneshot=0):
  - active = ch_en.
  - When ch_en falls: cnt <= 0, pulse <= 0, no pulse is emitted.
  - When ch_en rises: counting starts from 0. The first pulse is asserted divide+1 clks after the first active edge.
- One-shot mode (oneshot=1), requires ch_en=1:
  - start sets active and clears cnt.
  - The channel emits exactly one pulse at the wrap, then active <= 0 on that same edge.
  - start while active restarts the count from 0; there is no extra pulse.
  - start while ch_en=0 is ignored.
- sync:
  - Every channel with ch_en=1 gets cnt <= 0 and pulse <= 0 on that edge.
  - One-shot channels keep their active state.
  - Channels with ch_en=0 are unaffected.
- Priority per channel, same cycle: reset > ch_en=0 > sync > start > terminal-count wrap.
  - A sync on the wrap cycle suppresses that pulse.
- Divide register writes:
  - A div_wr on the same cycle as a wrap lands in the shadow register. It takes effect at the following wrap (one full old period later), not on this one.
  - Multiple div_wr bits may be set in one cycle; all selected channels load div_val.
- pulse_d:
  - Shift register of depth DLY fed by pulse.
  - It keeps flushing after ch_en falls or sync, so pulses already in the line still emerge.
  - Since DLY ≥ 1, pulse and pulse_d never assert on the same cycle when divide ≥ DLY.
- Width rules:
  - Counter and compare are CNT_W bits, unsigned.
  - No overflow is possible because the counter always wraps at or before the working divide value, which is ≤ 2^CNT_W-1.
- Reset mid-operation: everything returns to the reset state immediately. There are no residual pulses, including in the delay lines.

Test Plan:
- Reset, then div_wr[0] with div_val=4, then ch_en[0]=1 (continuous): pulse[0] repeats every 5 clks, and pulse_d[0] follows 1 clk later (DLY=1).
- Continuous, divide=0: pulse=1 on every cycle while ch_en=1. Drop ch_en: the next-cycle pulse is 0 and cnt=0.
- Channel 1 at divide 9: write div_val=2 three cycles after a pulse. The next pulse still arrives 10 clks after the previous one; after that the period is 3 clks.
- One-shot on channel 2, divide=6: start produces exactly one pulse 7 clks later, and active drops with it. A second start 3 clks after the first pushes that pulse out to 7 clks after the second start.
- Channels 0 and 3 at divide 4 running out of phase: assert sync, and both pulses coincide every 5 clks afterwards. A sync on a wrap cycle suppresses that pulse.
- Assert resetN=0 mid-count with a pulse in flight in the delay line (DLY=3): all outputs read 0 immediately, and no pulse_d appears after resetN is released.

Source files
------------

// File: rtl/multi_prescaler.sv
// ---------------------------------------------------------------------------
// multi_prescaler
// Multi-channel clock-enable generator. It divides clk into NUM_CH
// independent single-cycle enable pulses, one per channel. Each channel has
// its own divide value that can be changed while it runs, an optional
// one-shot mode and a delayed copy of its pulse. A global sync input
// realigns the phase of all enabled channels.
//
// Parameters:
//   NUM_CH  number of independent channels
//   CNT_W   width of each divide value and counter
//   DLY     delay of pulse_d behind pulse, in clk cycles (legal 1..8)
//
// Ports:
//   clk      system clock
//   resetN   asynchronous, active-low reset
//   ch_en    per-channel run enable (level)
//   oneshot  per-channel mode: 0 = continuous, 1 = one-shot (level)
//   start    per-channel one-shot trigger (1-cycle pulse)
//   sync     global phase realign (1-cycle pulse)
//   div_wr   per-channel write strobe for div_val
//   div_val  divide value written to every channel selected by div_wr
//   pulse    enable pulse, 1 clk wide, period = divide + 1
//   pulse_d  pulse delayed by DLY clks
//   active   channel is counting
// ---------------------------------------------------------------------------
module multi_prescaler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int DLY    = 1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] oneshot,
  input  logic [NUM_CH-1:0] start,
  input  logic              sync,
  input  logic [NUM_CH-1:0] div_wr,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] pulse,
  output logic [NUM_CH-1:0] pulse_d,
  output logic [NUM_CH-1:0] active
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chState_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh

    chState_t         state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadowDiv;
    logic [CNT_W-1:0] workDiv;
    logic             pulseR;
    logic [DLY-1:0]   dlyLine;
    logic             atTerminal;
    logic             takeWrap;

    // A wrap only happens when nothing of higher priority (disable, sync,
    // one-shot restart) claims the channel on this edge.
    assign atTerminal = (state == RUN) && (cnt >= workDiv);
    assign takeWrap   = atTerminal && ch_en[i] && !sync &&
                        !(oneshot[i] && start[i]);

    // Channel state, counter and divide registers. The working divide is
    // only refreshed from the shadow at a wrap or while idle, so a new value
    // written mid-period never shortens or stretches the running period.
    // Priority: disable > sync > one-shot start > idle restart > wrap.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        state     <= IDLE;
        cnt       <= '0;
        shadowDiv <= '0;
        workDiv   <= '0;
        pulseR    <= 1'b0;
      end else begin
        if (div_wr[i]) begin
          shadowDiv <= div_val;
        end
        if ((state == IDLE) || takeWrap) begin
          workDiv <= shadowDiv;
        end
        pulseR <= 1'b0;
        if (!ch_en[i]) begin
          state <= IDLE;
          cnt   <= '0;
        end else if (sync) begin
          // One-shot channels keep their run state; continuous ones run.
          cnt <= '0;
          if (!oneshot[i]) begin
            state <= RUN;
          end
        end else if (oneshot[i] && start[i]) begin
          state <= RUN;
          cnt   <= '0;
        end else if (state == IDLE) begin
          // An enabled continuous channel begins counting from zero here.
          cnt <= '0;
          if (!oneshot[i]) begin
            state <= RUN;
          end
        end else if (atTerminal) begin
          cnt    <= '0;
          pulseR <= 1'b1;
          if (oneshot[i]) begin
            state <= IDLE;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    // Delay line for pulse_d. It shifts regardless of ch_en or sync so that
    // pulses already launched still come out the far end.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        dlyLine <= '0;
      end else begin
        dlyLine <= DLY'({dlyLine, pulseR});
      end
    end

    assign pulse[i]   = pulseR;
    assign pulse_d[i] = dlyLine[DLY-1];
    assign active[i]  = (state == RUN);

  end

endmodule

// File: tb/tb_multi_prescaler.sv
// ---------------------------------------------------------------------------
// tb_multi_prescaler
// Self-checking bench for multi_prescaler. Two instances share all inputs:
// dutA uses DLY=1 and dutB uses DLY=3. A time-based reference model predicts
// pulse, pulse_d and active for every channel; a compare process checks both
// instances against it on every falling clock edge. Directed scenarios add
// hand-computed literal expectations for pulse spacing and reset behaviour.
// ---------------------------------------------------------------------------
module tb_multi_prescaler;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              resetN;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] oneshot;
  logic [NUM_CH-1:0] start;
  logic              sync;
  logic [NUM_CH-1:0] div_wr;
  logic [CNT_W-1:0]  div_val;

  logic [NUM_CH-1:0] pulseA, pulseDA, activeA;
  logic [NUM_CH-1:0] pulseB, pulseDB, activeB;

  int assertCount = 0;
  int failCount   = 0;

  always #10 clk = ~clk;

  multi_prescaler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DLY(1)) dutA (
    .clk(clk), .resetN(resetN), .ch_en(ch_en), .oneshot(oneshot),
    .start(start), .sync(sync), .div_wr(div_wr), .div_val(div_val),
    .pulse(pulseA), .pulse_d(pulseDA), .active(activeA)
  );

  multi_prescaler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DLY(3)) dutB (
    .clk(clk), .resetN(resetN), .ch_en(ch_en), .oneshot(oneshot),
    .start(start), .sync(sync), .div_wr(div_wr), .div_val(div_val),
    .pulse(pulseB), .pulse_d(pulseDB), .active(activeB)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0h, expected %0h at time %0t",
               name, actual, expected, $time);
    end
  endtask

  // Reference model. Each channel remembers the edge index of its last
  // restart/wrap; a pulse is due exactly divide+1 edges later. mHist[k] holds
  // the pulse vector produced k edges ago, which gives pulse_d for any delay.
  int         mT = 0;
  bit         mRun[NUM_CH];
  int         mRs[NUM_CH];
  int         mWork[NUM_CH];
  int         mShadow[NUM_CH];
  logic [3:0] mHist[0:8];
  logic [3:0] mNext;
  logic [3:0] mActive;
  bit         mWrap;
  bit         modelOn = 1'b0;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mT = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        mRun[c] = 1'b0; mRs[c] = 0; mWork[c] = 0; mShadow[c] = 0;
      end
      for (int k = 0; k <= 8; k++) mHist[k] = '0;
    end else begin
      mT++;
      mNext = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        mWrap = mRun[c] && ch_en[c] && !sync && !(oneshot[c] && start[c]) &&
                ((mT - mRs[c]) == (mWork[c] + 1));
        if (!mRun[c] || mWrap) mWork[c] = mShadow[c];
        if (div_wr[c]) mShadow[c] = int'(div_val);
        if (mWrap) mNext[c] = 1'b1;
        if (!ch_en[c]) begin
          mRun[c] = 1'b0;
        end else if (!oneshot[c]) begin
          if (!mRun[c] || sync || mWrap) mRs[c] = mT;
          mRun[c] = 1'b1;
        end else if (sync) begin
          mRs[c] = mT;
        end else if (start[c]) begin
          mRun[c] = 1'b1;
          mRs[c]  = mT;
        end else if (mWrap) begin
          mRun[c] = 1'b0;
          mRs[c]  = mT;
        end
      end
      for (int k = 8; k > 0; k--) mHist[k] = mHist[k-1];
      mHist[0] = mNext;
    end
  end

  // Compare process: both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (modelOn) begin
      for (int c = 0; c < NUM_CH; c++) mActive[c] = mRun[c];
      checkOutput("pulseA",   pulseA,   mHist[0]);
      checkOutput("pulseDA",  pulseDA,  mHist[1]);
      checkOutput("activeA",  activeA,  mActive);
      checkOutput("pulseB",   pulseB,   mHist[0]);
      checkOutput("pulseDB",  pulseDB,  mHist[3]);
      checkOutput("activeB",  activeB,  mActive);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One-cycle divide write to the channels in wrMask.
  task automatic applyStimulus(input logic [3:0] wrMask, input logic [15:0] val);
    step();
    div_wr  = wrMask;
    div_val = val;
    step();
    div_wr = '0;
  endtask

  // Counts falling edges until pulse[ch] is seen. Strobes are cleared after
  // every edge; at iteration midK an extra strobe set is applied for one cycle.
  task automatic countToPulse(input int ch, input int limit, input int midK,
                              input logic [3:0] mStart, input logic mSync,
                              input logic [3:0] mWr, input logic [15:0] mVal,
                              output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < limit) begin
      @(negedge clk);
      n++;
      found = pulseA[ch];
      #1;
      start  = '0;
      sync   = 1'b0;
      div_wr = '0;
      if (n == midK) begin
        start   = mStart;
        sync    = mSync;
        div_wr  = mWr;
        div_val = mVal;
      end
    end
    if (!found) n = -1;
  endtask

  int n;
  int extra;

  initial begin
    resetN = 1'b1; ch_en = '0; oneshot = '0; start = '0; sync = 1'b0;
    div_wr = '0; div_val = '0;
    #1 resetN = 1'b0;
    #5;
    checkOutput("resetState",
                {pulseA, pulseDA, activeA, pulseB, pulseDB, activeB}, 32'h0);
    step();
    resetN  = 1'b1;
    modelOn = 1'b1;

    // Continuous, divide 4: first pulse 5 edges after the enable edge.
    applyStimulus(4'b0001, 16'd4);
    ch_en[0] = 1'b1;
    countToPulse(0, 20, 0, '0, 1'b0, '0, '0, n);
    checkOutput("ch0FirstPulse", n, 6);
    countToPulse(0, 20, 0, '0, 1'b0, '0, '0, n);
    checkOutput("ch0Period5", n, 5);
    @(negedge clk);
    checkOutput("ch0PulseD1", {pulseA[0], pulseDA[0]}, 2'b01);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ch0PulseD3", pulseDB[0], 1'b1);

    // Continuous, divide 0: pulse on every cycle, drops right after disable.
    #1 ch_en[0] = 1'b0;
    applyStimulus(4'b0001, 16'd0);
    ch_en[0] = 1'b1;
    countToPulse(0, 10, 0, '0, 1'b0, '0, '0, n);
    checkOutput("div0First", n, 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("div0Every", pulseA[0], 1'b1);
    end
    #1 ch_en[0] = 1'b0;
    @(negedge clk);
    checkOutput("div0Drop", {pulseA[0], activeA[0]}, 2'b00);

    // Divide 9 reloaded to 2 mid-period: old period finishes, then 3.
    #1;
    applyStimulus(4'b0010, 16'd9);
    ch_en[1] = 1'b1;
    countToPulse(1, 20, 0, '0, 1'b0, '0, '0, n);
    checkOutput("ch1FirstPulse", n, 11);
    countToPulse(1, 20, 2, '0, 1'b0, 4'b0010, 16'd2, n);
    checkOutput("ch1OldPeriod", n, 10);
    countToPulse(1, 20, 0, '0, 1'b0, '0, '0, n);
    checkOutput("ch1NewPeriodA", n, 3);
    countToPulse(1, 20, 0, '0, 1'b0, '0, '0, n);
    checkOutput("ch1NewPeriodB", n, 3);
    ch_en[1] = 1'b0;

    // One-shot, divide 6.
    applyStimulus(4'b0100, 16'd6);
    oneshot[2] = 1'b1;
    ch_en[2]   = 1'b1;
    step();
    step();
    checkOutput("osIdle", activeA[2], 1'b0);
    start[2] = 1'b1;
    countToPulse(2, 20, 0, '0, 1'b0, '0, '0, n);
    checkOutput("osPulse", n, 8);
    checkOutput("osActiveDrop", activeA[2], 1'b0);
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pulseA[2]) extra++;
    end
    checkOutput("osNoRepeat", extra, 0);
    #1 start[2] = 1'b1;
    countToPulse(2, 20, 3, 4'b0100, 1'b0, '0, '0, n);
    checkOutput("osRestart", n, 11);

    // Channels 0 and 3, divide 4, out of phase, then realigned by sync.
    applyStimulus(4'b1001, 16'd4);
    ch_en[0] = 1'b1;
    step();
    step();
    ch_en[3] = 1'b1;
    step();
    step();
    step();
    sync = 1'b1;
    countToPulse(0, 20, 0, '0, 1'b0, '0, '0, n);
    checkOutput("syncFirst", n, 6);
    checkOutput("syncAligned", pulseA[3], 1'b1);
    countToPulse(0, 20, 0, '0, 1'b0, '0, '0, n);
    checkOutput("syncPeriod", n, 5);
    checkOutput("syncAligned2", pulseA[3], 1'b1);
    countToPulse(0, 20, 4, '0, 1'b1, '0, '0, n);
    checkOutput("syncOnWrap", n, 10);
    checkOutput("syncOnWrapCh3", pulseA[3], 1'b1);

    // Reset with a pulse still inside the DLY=3 line.
    resetN = 1'b0;
    ch_en  = '0;
    oneshot = '0;
    #1;
    checkOutput("midReset",
                {pulseA, pulseDA, activeA, pulseB, pulseDB, activeB}, 32'h0);
    step();
    step();
    resetN = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("noResidualPd", {pulseDA, pulseDB}, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d failures so far",
             failCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
